// File: rtl/tr_step_tracker.sv
// -----------------------------------------------------------------------------
// tr_step_tracker
//
// Sits directly after the stepper pulse generator. It detects every active
// step edge on drv_pulse, keeps a signed absolute position, counts steps,
// measures the period between steps and enforces soft travel limits by
// requesting a stop.
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   drv_pulse       : step pulse from the generator (already in clk domain)
//   invert_pulse    : 1 = pulses are active-low
//   dir             : 1 = positive travel, sampled with the step
//   limit_en        : enables soft-limit checking
//   lim_min/lim_max : signed soft limits
//   pos_load/pos_val: one-cycle load of the absolute position
//   cnt_clr         : one-cycle clear of step_cnt, overrun, overspeed
//   limit_clr       : one-cycle strobe that leaves HALT
//   position        : signed absolute position
//   step_cnt        : wrapping count of steps since the last cnt_clr
//   step_strobe     : one-cycle pulse per counted step
//   last_gap        : cycles between the two most recent steps
//   moving          : high in RUN
//   stop_req        : high in HALT
//   overrun         : sticky, step toward the violated limit while halted
//   overspeed       : sticky, step gap below MIN_GAP
//   dbg_state       : current FSM state (0 IDLE, 1 RUN, 2 HALT)
//
// Handshake: step_strobe is a valid-only event with no ready; it is high for
// exactly one cycle per counted step, and position/step_cnt/last_gap carry the
// values of that step in the same cycle.
// -----------------------------------------------------------------------------
module tr_step_tracker #(
    parameter int SIZE         = 16,
    parameter int GAPW         = 16,
    parameter int IDLE_TIMEOUT = 50000,
    parameter int MIN_GAP      = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            drv_pulse,
    input  logic            invert_pulse,
    input  logic            dir,
    input  logic            limit_en,
    input  logic [31:0]     lim_min,
    input  logic [31:0]     lim_max,
    input  logic            pos_load,
    input  logic [31:0]     pos_val,
    input  logic            cnt_clr,
    input  logic            limit_clr,
    output logic [31:0]     position,
    output logic [SIZE-1:0] step_cnt,
    output logic            step_strobe,
    output logic [GAPW-1:0] last_gap,
    output logic            moving,
    output logic            stop_req,
    output logic            overrun,
    output logic            overspeed,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [GAPW-1:0] LP_MIN_GAP = GAPW'(MIN_GAP);
    localparam logic [GAPW-1:0] LP_IDLE    = GAPW'(IDLE_TIMEOUT);
    localparam logic [GAPW-1:0] LP_GAP_MAX = '1;

    state_t          r_state;
    state_t          w_state_next;

    logic            w_a;
    logic            r_a;
    logic            r_a_q;
    logic            r_inv;
    logic            r_inv_q;
    logic            w_step;

    logic [31:0]     r_pos;
    logic [31:0]     w_pos_step;
    logic [31:0]     w_pos_new;
    logic [SIZE-1:0] r_cnt;
    logic            r_strobe;
    logic [GAPW-1:0] r_gap;
    logic [GAPW-1:0] r_last_gap;
    logic            r_ovr;
    logic            r_ovs;
    logic            r_halt_hi;     // 1 = HALT was entered on the upper limit
    logic            w_limit_hit;

    // ------------------------------------------------------------------
    // Edge detection. The active level and the invert bit are both
    // registered, and the edge is taken between the two registered copies,
    // so outputs follow one edge after the first edge that samples a = 1.
    // A cycle in which the registered invert bit changes is masked, which
    // means an invert flip can never look like a step.
    // ------------------------------------------------------------------
    assign w_a = drv_pulse ^ invert_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Preload both stages with the live level so a pulse that is
            // already active at reset is never counted.
            r_a     <= w_a;
            r_a_q   <= w_a;
            r_inv   <= invert_pulse;
            r_inv_q <= invert_pulse;
        end else begin
            r_a     <= w_a;
            r_a_q   <= r_a;
            r_inv   <= invert_pulse;
            r_inv_q <= r_inv;
        end
    end

    assign w_step = r_a & ~r_a_q & (r_inv == r_inv_q);

    // ------------------------------------------------------------------
    // Position arithmetic and limit test (signed, on the post-step value;
    // a coincident load supplies that value instead of the +/-1 result).
    // ------------------------------------------------------------------
    assign w_pos_step = dir ? (r_pos + 32'd1) : (r_pos - 32'd1);
    assign w_pos_new  = pos_load ? pos_val : w_pos_step;
    assign w_limit_hit = limit_en &&
                         (dir ? ($signed(w_pos_new) >= $signed(lim_max))
                              : ($signed(w_pos_new) <= $signed(lim_min)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_step) begin
                    w_state_next = w_limit_hit ? ST_HALT : ST_RUN;
                end else if (r_state == ST_RUN && r_gap >= LP_IDLE) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                // Only an explicit clear leaves HALT; dropping limit_en does not.
                if (limit_clr) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        moving    = (r_state == ST_RUN);
        stop_req  = (r_state == ST_HALT);
        dbg_state = r_state;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos      <= '0;
            r_cnt      <= '0;
            r_strobe   <= 1'b0;
            r_gap      <= '0;
            r_last_gap <= '0;
            r_ovr      <= 1'b0;
            r_ovs      <= 1'b0;
            r_halt_hi  <= 1'b0;
        end else begin
            r_strobe <= w_step;

            if (pos_load) begin
                r_pos <= pos_val;
            end else if (w_step) begin
                r_pos <= w_pos_step;
            end

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + SIZE'(1);
            end

            // Gap counter restarts at 1 so last_gap equals the step period.
            if (w_step) begin
                r_last_gap <= r_gap;
                r_gap      <= GAPW'(1);
            end else if (r_gap != LP_GAP_MAX) begin
                r_gap <= r_gap + GAPW'(1);
            end

            // The first step out of IDLE has no meaningful gap to judge.
            if (cnt_clr) begin
                r_ovs <= 1'b0;
            end else if (w_step && r_state != ST_IDLE && r_gap < LP_MIN_GAP) begin
                r_ovs <= 1'b1;
            end

            if (cnt_clr) begin
                r_ovr <= 1'b0;
            end else if (w_step && r_state == ST_HALT && dir == r_halt_hi) begin
                r_ovr <= 1'b1;
            end

            if (r_state != ST_HALT && w_state_next == ST_HALT) begin
                r_halt_hi <= dir;
            end
        end
    end

    assign position    = r_pos;
    assign step_cnt    = r_cnt;
    assign step_strobe = r_strobe;
    assign last_gap    = r_last_gap;
    assign overrun     = r_ovr;
    assign overspeed   = r_ovs;

endmodule

// File: tb/tb_tr_step_tracker.sv
module tb_tr_step_tracker;

    localparam int SIZE         = 16;
    localparam int GAPW         = 16;
    localparam int IDLE_TIMEOUT = 50000;
    localparam int MIN_GAP      = 1000;
    localparam int GAP_SAT      = (1 << GAPW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            drv_pulse = 1'b0;
    logic            invert_pulse = 1'b0;
    logic            dir = 1'b0;
    logic            limit_en = 1'b0;
    logic [31:0]     lim_min = 32'd0;
    logic [31:0]     lim_max = 32'd0;
    logic            pos_load = 1'b0;
    logic [31:0]     pos_val = 32'd0;
    logic            cnt_clr = 1'b0;
    logic            limit_clr = 1'b0;
    logic [31:0]     position;
    logic [SIZE-1:0] step_cnt;
    logic            step_strobe;
    logic [GAPW-1:0] last_gap;
    logic            moving;
    logic            stop_req;
    logic            overrun;
    logic            overspeed;
    logic [1:0]      dbg_state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tr_step_tracker #(
        .SIZE(SIZE), .GAPW(GAPW), .IDLE_TIMEOUT(IDLE_TIMEOUT), .MIN_GAP(MIN_GAP)
    ) dut (
        .clk(clk), .rst(rst), .drv_pulse(drv_pulse), .invert_pulse(invert_pulse),
        .dir(dir), .limit_en(limit_en), .lim_min(lim_min), .lim_max(lim_max),
        .pos_load(pos_load), .pos_val(pos_val), .cnt_clr(cnt_clr), .limit_clr(limit_clr),
        .position(position), .step_cnt(step_cnt), .step_strobe(step_strobe),
        .last_gap(last_gap), .moving(moving), .stop_req(stop_req),
        .overrun(overrun), .overspeed(overspeed), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]     pos;
        logic [SIZE-1:0] cnt;
        logic [GAPW-1:0] gap;
        logic            gap_chk;
        logic            ovs;
        logic            stop;
        logic            ovr;
        logic            mov;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every step_strobe must match the oldest predicted step.
    always @(negedge clk) begin
        if (step_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_step: got strobe expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_position", position, e.pos);
                chk("mon_step_cnt", 32'(step_cnt), 32'(e.cnt));
                if (e.gap_chk) chk("mon_last_gap", 32'(last_gap), 32'(e.gap));
                chk("mon_overspeed", 32'(overspeed), 32'(e.ovs));
                chk("mon_stop_req", 32'(stop_req), 32'(e.stop));
                chk("mon_overrun", 32'(overrun), 32'(e.ovr));
                chk("mon_moving", 32'(moving), 32'(e.mov));
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0]     m_pos;
    logic [SIZE-1:0] m_cnt;
    int              m_mode;
    bit              m_halt_hi, m_ovs, m_ovr, m_have_last;
    int              m_last_cyc;

    task automatic model_reset();
        m_pos = 0; m_cnt = 0; m_mode = M_IDLE; m_halt_hi = 0;
        m_ovs = 0; m_ovr = 0; m_have_last = 0; m_last_cyc = 0;
    endtask

    // One step whose active level is driven in the current cycle.
    task automatic model_step(input bit d, input bit ld, input logic [31:0] lv, input bit clr);
        int g;
        bit first;
        logic [31:0] np;
        exp_t e;
        g = m_have_last ? (cyc - m_last_cyc) : 0;
        if (g > GAP_SAT) g = GAP_SAT;
        if (m_mode == M_RUN && m_have_last && (cyc - m_last_cyc) > IDLE_TIMEOUT) m_mode = M_IDLE;
        first = (m_mode == M_IDLE);
        np = ld ? lv : (d ? m_pos + 32'd1 : m_pos - 32'd1);
        m_cnt = clr ? '0 : m_cnt + 1'b1;
        if (!first && g < MIN_GAP) m_ovs = 1;
        if (m_mode == M_HALT) begin
            if (d == m_halt_hi) m_ovr = 1;
        end else if (limit_en && (d ? ($signed(np) >= $signed(lim_max))
                                    : ($signed(np) <= $signed(lim_min)))) begin
            m_mode = M_HALT;
            m_halt_hi = d;
        end else begin
            m_mode = M_RUN;
        end
        if (clr) begin m_ovs = 0; m_ovr = 0; end
        m_pos = np;
        e.pos = np; e.cnt = m_cnt; e.gap = GAPW'(g); e.gap_chk = m_have_last;
        e.ovs = m_ovs; e.stop = (m_mode == M_HALT); e.ovr = m_ovr; e.mov = (m_mode == M_RUN);
        exp_q.push_back(e);
        m_have_last = 1;
        m_last_cyc = cyc;
    endtask

    // ---------------- driver tasks (entered #1 after a posedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending steps expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rst_dut();
        wait_drain();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        chk("rst_position", position, 32'd0);
        chk("rst_step_cnt", 32'(step_cnt), 32'd0);
        chk("rst_strobe", 32'(step_strobe), 32'd0);
        chk("rst_last_gap", 32'(last_gap), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_stop_req", 32'(stop_req), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_overspeed", 32'(overspeed), 32'd0);
    endtask

    // Active level for hi cycles, inactive for lo cycles. Optional load/clear
    // strobes are placed in the cycle in which the step takes effect.
    task automatic step_pulse(input bit d, input int hi, input int lo,
                              input bit ld = 1'b0, input logic [31:0] lv = 32'd0,
                              input bit clr = 1'b0);
        dir = d;
        drv_pulse = ~invert_pulse;
        model_step(d, ld, lv, clr);
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) drv_pulse = invert_pulse;
            @(posedge clk);
            #1;
            if (i == 0) begin
                pos_load = ld; pos_val = lv; cnt_clr = clr;
            end else begin
                pos_load = 1'b0; cnt_clr = 1'b0;
            end
        end
    endtask

    task automatic load_pos(input logic [31:0] v);
        pos_load = 1'b1; pos_val = v; m_pos = v;
        tick(1);
        pos_load = 1'b0;
        tick(1);
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1; m_cnt = 0; m_ovs = 0; m_ovr = 0;
        tick(1);
        cnt_clr = 1'b0;
        tick(1);
    endtask

    task automatic clr_lim();
        limit_clr = 1'b1;
        if (m_mode == M_HALT) m_mode = M_IDLE;
        tick(1);
        limit_clr = 1'b0;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_wait;
        int tmp;
        rst_dut();

        // Basic forward motion and idle timeout.
        for (int i = 0; i < 10; i++) step_pulse(1'b1, 5, 1995);
        chk("t1_position", position, 32'd10);
        chk("t1_step_cnt", 32'(step_cnt), 32'd10);
        chk("t1_last_gap", 32'(last_gap), 32'd2000);
        chk("t1_moving", 32'(moving), 32'd1);
        t_wait = m_last_cyc + IDLE_TIMEOUT - 10 - cyc;
        tick(t_wait);
        chk("t1_moving_before_timeout", 32'(moving), 32'd1);
        tick(25);
        chk("t1_moving_after_timeout", 32'(moving), 32'd0);

        // Active-low pulses, negative travel, invert toggles while idle.
        invert_pulse = 1'b1;
        drv_pulse = 1'b1;
        rst_dut();
        for (int i = 0; i < 5; i++) step_pulse(1'b0, 3, 17);
        chk("t2_position", position, 32'hFFFF_FFFB);
        invert_pulse = 1'b0;
        tick(5);
        invert_pulse = 1'b1;
        tick(5);
        chk("t2_position_after_toggle", position, 32'hFFFF_FFFB);
        chk("t2_step_cnt_after_toggle", 32'(step_cnt), 32'd5);
        invert_pulse = 1'b0;
        drv_pulse = 1'b0;

        // Soft limits, overrun, clear and re-entry.
        rst_dut();
        limit_en = 1'b1;
        lim_max = 32'd3;
        lim_min = -32'sd100;
        for (int i = 0; i < 5; i++) step_pulse(1'b1, 2, 18);
        chk("t3_overrun", 32'(overrun), 32'd1);
        step_pulse(1'b0, 2, 18);
        chk("t3_position_back", position, 32'd4);
        chk("t3_stop_req_held", 32'(stop_req), 32'd1);
        limit_en = 1'b0;
        tick(3);
        chk("t3_halt_kept_without_en", 32'(stop_req), 32'd1);
        limit_en = 1'b1;
        clr_lim();
        chk("t3_stop_after_clr", 32'(stop_req), 32'd0);
        chk("t3_moving_after_clr", 32'(moving), 32'd0);
        step_pulse(1'b1, 2, 18);
        chk("t3_reenter_halt", 32'(stop_req), 32'd1);
        limit_en = 1'b0;
        clr_lim();

        // Position load, 32-bit wrap, load coincident with a step.
        rst_dut();
        load_pos(32'h7FFF_FFFF);
        chk("t4_loaded", position, 32'h7FFF_FFFF);
        step_pulse(1'b1, 2, 18);
        chk("t4_wrap", position, 32'h8000_0000);
        step_pulse(1'b1, 2, 18, 1'b1, 32'h1234_5678);
        chk("t4_load_wins", position, 32'h1234_5678);
        chk("t4_cnt_with_load", 32'(step_cnt), 32'd2);

        // Overspeed, clear, clear coincident with a step.
        rst_dut();
        step_pulse(1'b1, 5, 495);
        step_pulse(1'b1, 5, 1195);
        chk("t5_overspeed", 32'(overspeed), 32'd1);
        chk("t5_last_gap", 32'(last_gap), 32'd500);
        clr_cnt();
        chk("t5_overspeed_clr", 32'(overspeed), 32'd0);
        chk("t5_step_cnt_clr", 32'(step_cnt), 32'd0);
        step_pulse(1'b1, 5, 45, 1'b0, 32'd0, 1'b1);
        chk("t5_cnt_clr_with_step", 32'(step_cnt), 32'd0);

        // Reset while the pulse is still active.
        rst_dut();
        dir = 1'b1;
        drv_pulse = 1'b1;
        model_step(1'b1, 1'b0, 32'd0, 1'b0);
        tick(3);
        rst_dut();
        drv_pulse = 1'b0;
        tick(5);
        chk("t6_no_step_after_rst", 32'(step_cnt), 32'd0);
        chk("t6_position_after_rst", position, 32'd0);

        // Randomised motion with limits, loads and limit clears.
        rst_dut();
        limit_en = 1'b1;
        lim_max = 32'($urandom_range(3, 10));
        tmp = $urandom_range(3, 10);
        lim_min = -tmp;
        for (int i = 0; i < 16; i++) begin
            int p, hi, lv;
            bit d, ld;
            d  = 1'($urandom_range(0, 1));
            p  = $urandom_range(2, 600);
            hi = $urandom_range(1, (p - 1 > 4) ? 4 : p - 1);
            ld = ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 20) - 10;
            step_pulse(d, hi, p - hi, ld, 32'(lv));
            if ($urandom_range(0, 3) == 0) clr_lim();
        end
        chk("rnd_position", position, m_pos);
        chk("rnd_step_cnt", 32'(step_cnt), 32'(m_cnt));

        wait_drain();
        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tr_step_tracker.md
# tr_step_tracker

Step-tracking stage placed directly downstream of the stepper pulse generator. It consumes `drv_pulse` and counts each active step edge, honouring the generator's invert bit. It maintains a signed absolute position and measures step period. It enforces soft travel limits by raising a `stop_req` that the command logic maps to the generator's stop bit.

## Interface
Parameters:
- `SIZE`, 16, width of relative step counter `step_cnt`
- `GAPW`, 16, width of gap counter and `last_gap`
- `IDLE_TIMEOUT`, 50000, cycles without a step before `moving` drops (1 ms at 50 MHz)
- `MIN_GAP`, 1000, minimum legal cycles between steps (50 kHz ceiling)

Ports:
- `clk` in 1: 50 MHz system clock; single clock domain
- `rst` in 1: reset, synchronous, active-high
- `drv_pulse` in 1: step pulse from pulse generator, already registered in `clk` domain
- `invert_pulse` in 1: same bit as generator control bit 5; 1 = active-low pulses
- `dir` in 1: 1 = positive travel, 0 = negative; sampled on step edge
- `limit_en` in 1: enables soft-limit checking
- `lim_min` in 32: signed lower soft limit
- `lim_max` in 32: signed upper soft limit
- `pos_load` in 1: one-cycle strobe, loads `pos_val` into position
- `pos_val` in 32: signed load value
- `cnt_clr` in 1: one-cycle strobe, clears `step_cnt`, `overrun`, `overspeed`
- `limit_clr` in 1: one-cycle strobe, leaves HALT
- `position` out 32: signed absolute position
- `step_cnt` out SIZE: steps since last `cnt_clr`, wraps
- `step_strobe` out 1: one-cycle pulse per counted step
- `last_gap` out GAPW: cycles between the two most recent steps
- `moving` out 1: high in RUN
- `stop_req` out 1: high in HALT
- `overrun` out 1: sticky; step toward a limit while in HALT
- `overspeed` out 1: sticky; step gap < `MIN_GAP`

## Operation
- Active level `a = drv_pulse ^ invert_pulse`, registered as `a_q`. A step is `a & !a_q`.
- If `invert_pulse` differs from its registered copy, step detection is suppressed that cycle and `a_q` takes the new `a`. An invert change never counts a step.
- Per step:
  - `position` ±1 per `dir`, 32-bit two's-complement wrap.
  - `step_cnt` +1, wraps at 2^SIZE.
  - `step_strobe` = 1.
  - `last_gap` takes the gap counter value; gap counter restarts at 1.
- Gap counter increments every cycle and saturates at 2^GAPW−1.
- `overspeed` sets on a step with gap < `MIN_GAP`. It is not evaluated on the first step after IDLE.
- `pos_load` with a simultaneous step: the load wins for `position`. `step_cnt`, `step_strobe` and `last_gap` still update.
- `cnt_clr` with a simultaneous step: `step_cnt` = 0, not 1.
- FSM states IDLE, RUN, HALT:
  - IDLE→RUN on a step.
  - RUN→IDLE when the gap counter reaches `IDLE_TIMEOUT`.
  - IDLE/RUN→HALT when `limit_en` and the new position is ≥ `lim_max` (dir=1) or ≤ `lim_min` (dir=0). All comparisons are signed.
  - HALT→IDLE on `limit_clr`, even if the position is still at the limit. A further step toward that limit re-enters HALT.
  - `rst` in any state → IDLE.
- In HALT, steps are still counted, because the generator stops with latency.
  - A step toward the violated limit sets `overrun`.
  - A step away from it is legal and does not set `overrun`.
- `limit_en` = 0 never enters HALT. Deasserting `limit_en` while in HALT does not exit; only `limit_clr` exits.
- If `lim_min` > `lim_max`, every step enters HALT. This is allowed and not checked.

## Timing
- Reset values:
  - `position`, `step_cnt`, `last_gap` = 0.
  - `step_strobe`, `moving`, `stop_req`, `overrun`, `overspeed` = 0.
  - State = IDLE; gap counter = 0.
  - `a_q` = `drv_pulse ^ invert_pulse` at reset, so no step is detected on the first cycle after reset.
- Latency, taking edge k as the first clock edge where `a` = 1:
  - `step_strobe`, `position`, `step_cnt`, `last_gap` update at edge k+1.
  - `stop_req` and `moving` go high at edge k+1, registered from the next-state value.
- `pos_load`, `cnt_clr` and `limit_clr` take effect at the edge following their high cycle.
- Minimum resolvable step: `a` high 1 cycle, low 1 cycle.
- `rst` mid-motion clears everything at the next edge. A pulse that is still high after reset is not counted.

## Test plan
- Reset, then 10 active-high pulses, 2000-cycle period, dir=1 → `position`=10, `step_cnt`=10, `last_gap`=2000, `moving`=1; `moving`=0 after 50000 idle cycles.
- `invert_pulse`=1, `drv_pulse` idle high, 5 low pulses, dir=0 → `position`=−5. Toggling `invert_pulse` while idle adds no step.
- `limit_en`=1, `lim_max`=3, dir=1, 5 steps → `stop_req` at step 3, `overrun`=1 after step 4, `position`=5. Then dir=0, 1 step → `position`=4, no new overrun. `limit_clr` → IDLE.
- `pos_load` with `pos_val`=0x7FFFFFFF, then 1 step dir=1 → `position`=0x80000000 (wrap). Load coincident with a step → `position`=`pos_val`, `step_cnt` incremented.
- Two steps 500 cycles apart → `overspeed`=1, `last_gap`=500. `cnt_clr` → `overspeed`=0, `step_cnt`=0.
- `rst` asserted while `drv_pulse` is high mid-run → all outputs at reset values, and no step when `drv_pulse` falls.
